// File: rtl/imm_gen_pipe.sv
// Immediate decoder feeding a 2-entry skid FIFO. Decode is combinational on the
// input side. The output side presents the head entry, or zeros when the FIFO is empty.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_sel,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNTW  = 2;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [TAGW-1:0] tag;
    logic            err;
  } entry_t;

  entry_t            entry_d;
  entry_t            mem_q [DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              push_c, pop_c;
  logic              unused_opcode;

  // Opcode bits never contribute to any immediate format.
  assign unused_opcode = ^in_instr[6:0];

  // Immediate decode.
  always_comb begin
    entry_d     = '0;
    entry_d.tag = in_tag;
    case (in_sel)
      3'b001: entry_d.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      3'b010: entry_d.imm = XLEN'($signed(in_instr[31:20]));
      3'b011: entry_d.imm = (XLEN == 64) ? XLEN'(in_instr[25:20])
                                         : XLEN'(in_instr[24:20]);
      3'b100: entry_d.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                           in_instr[11:8], 1'b0}));
      3'b101: entry_d.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'b110: entry_d.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                           in_instr[30:21], 1'b0}));
      3'b111: entry_d.imm = XLEN'(in_instr[19:15]);
      default: entry_d.err = 1'b1;
    endcase
  end

  assign in_ready  = (count_q != CNTW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = ~wr_ptr_q;
    if (pop_c)  rd_ptr_d = ~rd_ptr_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset and flush both empty the FIFO; reset simply wins when both are high.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push_c && !flush && !rst) mem_q[wr_ptr_q] <= entry_d;
  end

  assign out_imm = out_valid ? mem_q[rd_ptr_q].imm : '0;
  assign out_tag = out_valid ? mem_q[rd_ptr_q].tag : '0;
  assign out_err = out_valid ? mem_q[rd_ptr_q].err : 1'b0;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32: output immediate width; legal values are 32 and 64.
REQ-002 Parameter TAGW, default 8: width of the sideband tag carried with each instruction.
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port flush  input  1: synchronous clear of all buffered entries.
REQ-006 Port in_valid  input  1: the input word is valid this cycle.
REQ-007 Port in_ready  output  1: the block can accept a word this cycle.
REQ-008 Port in_instr  input  32: the instruction word, bits [31:0].
REQ-009 Port in_sel  input  3: immediate format select.
REQ-010 Port in_tag  input  TAGW: sideband tag, passed through unchanged.
REQ-011 Port out_valid  output  1: the output entry is valid.
REQ-012 Port out_ready  input  1: the consumer accepts the output entry this cycle.
REQ-013 Port out_imm  output  XLEN: the decoded immediate.
REQ-014 Port out_tag  output  TAGW: the tag paired with out_imm.
REQ-015 Port out_err  output  1: in_sel was illegal for this entry.

Function
REQ-016 Decode SHALL be combinational on the input side; the result is written into a 2-entry FIFO (skid buffer), and out_* always present the head entry.
REQ-017 Select encodings and outputs:
- 001 U: {in[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
- 010 I: in[31:20], sign-extended.
- 011 SHAMT: zero-extended in[24:20] when XLEN=32, or in[25:20] when XLEN=64.
- 100 B: {in[31], in[7], in[30:25], in[11:8], 1'b0}, sign-extended.
- 101 S: {in[31:25], in[11:7]}, sign-extended.
- 110 J: {in[31], in[19:12], in[20], in[30:21], 1'b0}, sign-extended.
- 111 CSR-uimm: in[19:15], zero-extended.
REQ-018 Sel 000 SHALL store imm = 0 with err = 1; all other encodings store err = 0.
REQ-019 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-020 in_ready SHALL be asserted exactly when count < 2 and SHALL depend only on registered state, never combinationally on out_ready.
REQ-021 out_valid SHALL be asserted exactly when count > 0.
REQ-022 Latency: a word pushed in cycle N SHALL appear on out_* in cycle N+1 at the earliest.
REQ-023 Entries SHALL leave in push order.
REQ-024 Count transitions:
- push alone: +1.
- pop alone: -1.
- push and pop in the same cycle: count unchanged.
REQ-025 Push and pop in the same cycle with count = 1: the new word becomes head in the next cycle.
REQ-026 Push with count = 2 SHALL not occur; in_valid is ignored because in_ready = 0.
REQ-027 out_imm, out_tag and out_err SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-028 Read and write pointers SHALL wrap modulo 2.
REQ-029 flush SHALL set count to 0 in the next cycle, discarding any same-cycle push and pop.
REQ-030 flush SHALL take priority over push and pop.
REQ-031 When out_valid = 0, out_imm, out_tag and out_err SHALL be 0.

Reset
REQ-032 When rst = 1 at a clock edge, the block SHALL set count = 0 and both pointers = 0; consequently out_valid = 0, out_imm = 0, out_tag = 0, out_err = 0 and in_ready = 1 in the next cycle.
REQ-033 rst SHALL override flush, push and pop, including mid-transfer; any buffered entries are lost.
REQ-034 Storage contents need no reset, provided REQ-031 holds.

Verification
REQ-035 XLEN=32:
- instr 0xFE000EE3, sel 100, tag 0x5A, out_ready=1 -> next cycle out_imm 0xFFFFFFFC, out_tag 0x5A, out_err 0.
- instr 0x12345037, sel 001 -> out_imm 0x12345000.
REQ-036 XLEN=64:
- instr 0xFFF00093, sel 010 -> out_imm 0xFFFFFFFFFFFFFFFF.
- instr 0x03F01013, sel 011 -> out_imm 63.
- same instr, sel 011, with XLEN=32 -> out_imm 31.
REQ-037 out_ready=0; push tags 1, 2 and 3 back-to-back -> in_ready falls after the second push, tag 3 is held off, out_tag stays 1; raise out_ready -> out_tag sequence 1, 2, 3 with no loss or duplication.
REQ-038 Sel 000 with any instr -> out_imm 0, out_err 1; the next entry with sel 111 and instr 0x000F8073 -> out_imm 31, out_err 0.
REQ-039 Two entries buffered:
- assert flush together with in_valid -> next cycle out_valid 0, in_ready 1, and the flushed-cycle word is absent.
- repeat the same sequence with rst instead of flush -> same result.
REQ-040 Random stimulus over in_valid, out_ready and sel against a queue reference model -> order, values and stability (REQ-027) match on every cycle for at least 10k cycles.
